// File: rtl/rnn_seq_feeder.sv
// rtl/rnn_seq_feeder.sv - sequence buffer and launcher feeding the recurrent core
// Ports: clk/rst (sync, active-high); s_valid/s_ready/s_data/s_last sample input;
// x_bus/x_valid/x_last/step_idx/core_rst_n drive the core; y_in core output,
// y_out/y_valid captured final-step result; err_long sticky overlong flag.
// Optional macro RNN_SEQ_STATS_EN adds seq_count and drop_count counters.
module rnn_seq_feeder #(
    parameter int INPUT_SIZE = 1,
    parameter int BW_IN      = 32,
    parameter int BW_OUT     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int IDX_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [INPUT_SIZE*BW_IN-1:0] s_data,
    input  logic                        s_last,
    output logic [INPUT_SIZE*BW_IN-1:0] x_bus,
    output logic                        x_valid,
    output logic                        x_last,
    output logic [IDX_W-1:0]            step_idx,
    output logic                        core_rst_n,
    input  logic [BW_OUT-1:0]           y_in,
    output logic [BW_OUT-1:0]           y_out,
    output logic                        y_valid,
    output logic                        err_long
`ifdef RNN_SEQ_STATS_EN
    ,
    output logic [15:0]                 seq_count,
    output logic [15:0]                 drop_count
`endif
);
    localparam int DW = INPUT_SIZE * BW_IN;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;
    state_t state, state_nxt;

    logic [DW:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_cnt, seq_cnt, seq_cnt_nxt;
    logic             full, rdy_q, discard, overflow;
    logic             accept, push, pop, push_last, pop_last;
    logic [DW-1:0]    head_data;
    logic             head_last;
    logic [IDX_W-1:0] step_cnt;

    logic             x_valid_d, x_last_d, core_rst_n_d;
    logic [DW-1:0]    x_bus_d;
    logic [IDX_W-1:0] step_idx_d;

    assign full      = (fifo_cnt == CW'(FIFO_DEPTH));
    // While discarding an overlong sequence the input is drained regardless of fill.
    assign s_ready   = rdy_q && (!full || discard);
    assign accept    = s_valid && s_ready;
    assign push      = accept && !discard;
    assign push_last = push && s_last;
    assign pop_last  = pop && head_last;
    assign {head_last, head_data} = mem[rd_ptr];
    // A full buffer with no complete sequence can never launch: it is overlong.
    assign overflow  = full && (seq_cnt == '0) && !discard;

    always_comb begin
        seq_cnt_nxt = seq_cnt;
        if (push_last && !pop_last)
            seq_cnt_nxt = seq_cnt + CW'(1);
        else if (!push_last && pop_last)
            seq_cnt_nxt = seq_cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {s_last, s_data};
    end

    always_ff @(posedge clk) begin
        if (rst || overflow) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fifo_cnt <= fifo_cnt + CW'(1);
            else if (!push && pop)
                fifo_cnt <= fifo_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q    <= 1'b0;
            seq_cnt  <= '0;
            discard  <= 1'b0;
            err_long <= 1'b0;
        end else begin
            rdy_q   <= 1'b1;
            seq_cnt <= seq_cnt_nxt;
            if (overflow) begin
                discard  <= 1'b1;
                err_long <= 1'b1;
            end else if (discard && accept && s_last) begin
                discard <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (seq_cnt != '0) state_nxt = CLEAR;
            CLEAR:   state_nxt = RUN;
            RUN:     if (head_last) state_nxt = (seq_cnt_nxt != '0) ? CLEAR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop          = 1'b0;
        x_valid_d    = 1'b0;
        x_last_d     = 1'b0;
        x_bus_d      = '0;
        step_idx_d   = '0;
        core_rst_n_d = 1'b1;
        case (state)
            CLEAR: core_rst_n_d = 1'b0;
            RUN: begin
                pop        = 1'b1;
                x_valid_d  = 1'b1;
                x_last_d   = head_last;
                x_bus_d    = head_data;
                step_idx_d = step_cnt;
            end
            default: ;
        endcase
    end

    // Core-facing outputs are registered, so they trail the FSM state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_bus      <= '0;
            x_valid    <= 1'b0;
            x_last     <= 1'b0;
            step_idx   <= '0;
            core_rst_n <= 1'b0;
            step_cnt   <= '0;
            y_out      <= '0;
            y_valid    <= 1'b0;
        end else begin
            x_bus      <= x_bus_d;
            x_valid    <= x_valid_d;
            x_last     <= x_last_d;
            step_idx   <= step_idx_d;
            core_rst_n <= core_rst_n_d;
            if (state == CLEAR)
                step_cnt <= '0;
            else if (pop)
                step_cnt <= step_cnt + IDX_W'(1);
            y_valid <= x_valid && x_last;
            if (x_valid && x_last)
                y_out <= y_in;
        end
    end

`ifdef RNN_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_count  <= '0;
            drop_count <= '0;
        end else begin
            if (y_valid && seq_count != 16'hFFFF)
                seq_count <= seq_count + 16'd1;
            if (overflow && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rnn_seq_feeder.sv
// tb/tb_rnn_seq_feeder.sv - directed self-checking bench for rnn_seq_feeder
module tb_rnn_seq_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [31:0] x_bus;
    logic        x_valid;
    logic        x_last;
    logic [7:0]  step_idx;
    logic        core_rst_n;
    logic [31:0] y_in = '0;
    logic [31:0] y_out;
    logic        y_valid;
    logic        err_long;
`ifdef RNN_SEQ_STATS_EN
    logic [15:0] seq_count;
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rnn_seq_feeder dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .x_bus(x_bus), .x_valid(x_valid), .x_last(x_last), .step_idx(step_idx),
        .core_rst_n(core_rst_n), .y_in(y_in), .y_out(y_out), .y_valid(y_valid),
        .err_long(err_long)
`ifdef RNN_SEQ_STATS_EN
        , .seq_count(seq_count), .drop_count(drop_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (!s_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_ready", 32'(s_ready), 1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!x_valid && n < 30) begin
            step();
            n++;
        end
        chk(tag, 32'(x_valid), 1);
    endtask

    initial begin
        int pi, oi, acc;
        // reset state
        step();
        step();
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_x_valid", 32'(x_valid), 0);
        chk("rst_core_rst_n", 32'(core_rst_n), 0);
        chk("rst_x_bus", x_bus, 0);
        chk("rst_step_idx", 32'(step_idx), 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_y_valid", 32'(y_valid), 0);
        chk("rst_err_long", 32'(err_long), 0);
        rst = 1'b0;
        step();
        chk("post_rst_s_ready", 32'(s_ready), 1);
        chk("post_rst_core_rst_n", 32'(core_rst_n), 1);

        // single 3-sample sequence
        y_in = 32'h1234;
        push(1, 0);
        push(2, 0);
        push(3, 1);
        step();
        chk("t1_idle_core_rst_n", 32'(core_rst_n), 1);
        step();
        chk("t1_clear_core_rst_n", 32'(core_rst_n), 0);
        chk("t1_clear_x_valid", 32'(x_valid), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_x_valid", 32'(x_valid), 1);
            chk("t1_x_bus", x_bus, i + 1);
            chk("t1_step_idx", 32'(step_idx), i);
            chk("t1_x_last", 32'(x_last), (i == 2) ? 1 : 0);
            chk("t1_core_rst_n", 32'(core_rst_n), 1);
        end
        step();
        chk("t1_y_valid", 32'(y_valid), 1);
        chk("t1_y_out", y_out, 32'h1234);
        chk("t1_x_valid_after", 32'(x_valid), 0);
        step();
        chk("t1_y_valid_pulse", 32'(y_valid), 0);
        chk("t1_y_out_hold", y_out, 32'h1234);

        // two back-to-back 2-sample sequences
        y_in = 32'h1111;
        push(32'hA, 0);
        push(32'hB, 1);
        push(32'hC, 0);
        push(32'hD, 1);
        chk("t2_clear1_core_rst_n", 32'(core_rst_n), 0);
        step();
        chk("t2_a", x_bus, 32'hA);
        chk("t2_a_valid", 32'(x_valid), 1);
        step();
        chk("t2_b", x_bus, 32'hB);
        chk("t2_b_last", 32'(x_last), 1);
        step();
        chk("t2_bubble_x_valid", 32'(x_valid), 0);
        chk("t2_bubble_core_rst_n", 32'(core_rst_n), 0);
        chk("t2_y_valid1", 32'(y_valid), 1);
        chk("t2_y_out1", y_out, 32'h1111);
        y_in = 32'h2222;
        step();
        chk("t2_c", x_bus, 32'hC);
        chk("t2_c_idx", 32'(step_idx), 0);
        step();
        chk("t2_d", x_bus, 32'hD);
        chk("t2_d_idx", 32'(step_idx), 1);
        chk("t2_d_last", 32'(x_last), 1);
        step();
        chk("t2_y_valid2", 32'(y_valid), 1);
        chk("t2_y_out2", y_out, 32'h2222);

        // overlong sequence followed by a good one
        for (int i = 0; i < 16; i++) push(100 + i, 0);
        chk("t3_full_s_ready", 32'(s_ready), 0);
        step();
        chk("t3_err_long", 32'(err_long), 1);
        chk("t3_discard_s_ready", 32'(s_ready), 1);
        push(200, 0);
        push(201, 0);
        push(202, 1);
        push(300, 0);
        push(301, 1);
        wait_valid("t3_wait_valid");
        chk("t3_first", x_bus, 300);
        chk("t3_first_idx", 32'(step_idx), 0);
        step();
        chk("t3_second", x_bus, 301);
        chk("t3_second_last", 32'(x_last), 1);
        chk("t3_second_idx", 32'(step_idx), 1);
        step();
        step();
        chk("t3_err_sticky", 32'(err_long), 1);

        // 10-sample and 6-sample sequences streamed with s_valid held
        pi = 0;
        oi = 0;
        for (int cyc = 0; cyc < 80 && oi < 16; cyc++) begin
            if (pi < 16) begin
                s_valid = 1'b1;
                s_data  = 400 + pi;
                s_last  = (pi == 9 || pi == 15);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            acc = (s_valid && s_ready) ? 1 : 0;
            step();
            if (acc == 1) pi++;
            if (x_valid) begin
                chk("t4_x_bus", x_bus, 400 + oi);
                chk("t4_x_last", 32'(x_last), (oi == 9 || oi == 15) ? 1 : 0);
                chk("t4_step_idx", 32'(step_idx), (oi < 10) ? oi : oi - 10);
                oi++;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("t4_all_played", oi, 16);
        step();
        step();

        // reset in the middle of a sequence
        push(500, 0);
        push(501, 0);
        push(502, 0);
        push(503, 1);
        for (int n = 0; n < 20; n++) begin
            if (x_valid && step_idx == 8'd1) break;
            step();
        end
        chk("t5_at_idx1", 32'(step_idx), 1);
`ifdef RNN_SEQ_STATS_EN
        chk("stats_seq_count", 32'(seq_count), 6);
        chk("stats_drop_count", 32'(drop_count), 1);
`endif
        rst = 1'b1;
        step();
        chk("t5_rst_x_valid", 32'(x_valid), 0);
        chk("t5_rst_core_rst_n", 32'(core_rst_n), 0);
        chk("t5_rst_s_ready", 32'(s_ready), 0);
        rst = 1'b0;
        step();
        chk("t5_rel_s_ready", 32'(s_ready), 1);
        chk("t5_rel_err_long", 32'(err_long), 0);
        repeat (5) step();
        chk("t5_empty_x_valid", 32'(x_valid), 0);
        chk("t5_idle_core_rst_n", 32'(core_rst_n), 1);
        push(600, 0);
        push(601, 1);
        wait_valid("t5_wait_valid");
        chk("t5_first", x_bus, 600);
        chk("t5_first_idx", 32'(step_idx), 0);
        step();
        chk("t5_second", x_bus, 601);
        chk("t5_second_last", 32'(x_last), 1);
        step();
        step();
`ifdef RNN_SEQ_STATS_EN
        chk("stats_seq_count_after_rst", 32'(seq_count), 1);
        chk("stats_drop_count_after_rst", 32'(drop_count), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
